video_ram_responder: RTL and testbench

Memory-side responder for the video fetch interface. It answers the video controller's per-pixel-period read address (vid_addr) with data (vid_dout, wired to the controller's din) in time for the next ce_pix. It time-multiplexes a single-port byte RAM between those video reads and CPU accesses, using a fixed 4-phase slot scheme locked to ce_pix. It sits between the video controller, the CPU memory bridge and the 128K video/main RAM.

---
 rtl/video_ram_responder.sv | 93 +++++++++
 tb/tb_video_ram_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_ram_responder.sv
// Memory-side responder: shares one single-port byte RAM between per-pixel video reads
// and CPU accesses using a 4-phase slot scheme locked to ce_pix.
module video_ram_responder #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ce_pix,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_dout,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] PH_VID_ISSUE = 2'd0;
   localparam logic [1:0] PH_CPU_ISSUE = 2'd2;

   logic [1:0] ph;
   logic       vid_rvalid_d;  // video RAM op in progress this cycle
   logic       vid_cap_d;     // mem_rdata holds video data this cycle
   logic       cpu_op_d;      // CPU RAM op in progress this cycle
   logic       cpu_cap_d;     // mem_rdata holds CPU data this cycle
   logic       cpu_is_rd;
   logic       cpu_busy;
   logic       vid_slot;
   logic       cpu_slot;

   // CPU handshake: cpu_req is a level held with stable cpu_we/addr/wdata until cpu_ack;
   // cpu_ack is a single-cycle pulse. A request still high at a later ph 2 edge is new.
   assign vid_slot = (ph == PH_VID_ISSUE);
   assign cpu_slot = (ph == PH_CPU_ISSUE) && cpu_req && !cpu_busy && !vid_slot;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         ph           <= 2'd0;
         vid_dout     <= '0;
         cpu_rdata    <= '0;
         cpu_ack      <= 1'b0;
         mem_addr     <= '0;
         mem_rd       <= 1'b0;
         mem_we       <= 1'b0;
         mem_wdata    <= '0;
         vid_rvalid_d <= 1'b0;
         vid_cap_d    <= 1'b0;
         cpu_op_d     <= 1'b0;
         cpu_cap_d    <= 1'b0;
         cpu_is_rd    <= 1'b0;
         cpu_busy     <= 1'b0;
      end else begin
         ph           <= ce_pix ? 2'd0 : ph + 2'd1;
         mem_rd       <= 1'b0;
         mem_we       <= 1'b0;
         vid_rvalid_d <= 1'b0;
         cpu_op_d     <= 1'b0;

         if (vid_slot) begin
            mem_addr     <= vid_addr;
            mem_rd       <= 1'b1;
            vid_rvalid_d <= 1'b1;
         end else if (cpu_slot) begin
            mem_addr  <= cpu_addr;
            mem_we    <= cpu_we;
            mem_rd    <= ~cpu_we;
            mem_wdata <= cpu_wdata;
            cpu_op_d  <= 1'b1;
            cpu_is_rd <= ~cpu_we;
            cpu_busy  <= 1'b1;
         end

         // Delay flags rather than ph decode, so a resync neither drops nor repeats a capture.
         vid_cap_d <= vid_rvalid_d;
         cpu_cap_d <= cpu_op_d;
         if (vid_cap_d)
            vid_dout <= mem_rdata;
         if (cpu_cap_d && cpu_is_rd)
            cpu_rdata <= mem_rdata;
         cpu_ack <= cpu_cap_d;
         if (cpu_cap_d)
            cpu_busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_video_ram_responder.sv
// Directed bench for video_ram_responder: RAM model, ce_pix generator and per-scenario tasks.
module tb_video_ram_responder;
   localparam int AW = 17;
   localparam int DW = 8;

   logic          clk_sys = 1'b0;
   logic          reset, ce_pix, cpu_req, cpu_we, cpu_ack, mem_rd, mem_we;
   logic [AW-1:0] vid_addr, cpu_addr, mem_addr;
   logic [DW-1:0] vid_dout, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;

   logic [DW-1:0] ram [0:(1<<AW)-1];
   bit            ram_loaded = 1'b0;
   int            n_cmp = 0;
   int            n_fail = 0;
   logic [1:0]    ce_div;   // bench copy of the expected phase
   bit            ce_en;

   video_ram_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
      .vid_addr(vid_addr), .vid_dout(vid_dout),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #8 clk_sys = ~clk_sys;

   // RAM model: read data valid one cycle after the mem_rd cycle
   always @(posedge clk_sys) begin
      if (!ram_loaded) begin
         for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
         ram[17'h00100] <= 8'hA5;
         ram[17'h00200] <= 8'h11;
         ram[17'h00010] <= 8'h5A;
         ram[17'h00300] <= 8'h77;
         ram_loaded <= 1'b1;
      end else begin
         if (mem_rd) mem_rdata <= ram[mem_addr];
         if (mem_we) ram[mem_addr] <= mem_wdata;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
      if (ce_pix) ce_div = 2'd0;
      else        ce_div = ce_div + 2'd1;
      ce_pix = ce_en && (ce_div == 2'd3);
   endtask

   task automatic wait_ph(input logic [1:0] p);
      int k;
      k = 0;
      while (ce_div != p && k < 8) begin
         tick();
         k++;
      end
   endtask

   task automatic test_reset();
      int acks;
      tick(); tick(); tick();
      n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      n_cmp++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
      n_cmp++; if (vid_dout !== '0) begin n_fail++; $display("FAIL rst_vid_dout: got %h want 0", vid_dout); end
      n_cmp++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_rdata); end
      n_cmp++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ack: got %b want 0", cpu_ack); end
      // release, start a CPU read, then reset during its RAM op
      reset = 1'b0; ce_div = 2'd0; ce_en = 1'b1; ce_pix = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00010;
      tick(); tick(); tick();
      n_cmp++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL pre_rst_cpu_rd: got %b want 1", mem_rd); end
      n_cmp++; if (mem_addr !== 17'h00010) begin n_fail++; $display("FAIL pre_rst_cpu_addr: got %h want 00010", mem_addr); end
      reset = 1'b1;
      #1;
      n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL async_rst_mem_rd: got %b want 0", mem_rd); end
      n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL async_rst_mem_addr: got %h want 0", mem_addr); end
      cpu_req = 1'b0; ce_en = 1'b0; ce_pix = 1'b0;
      tick(); tick();
      reset = 1'b0; ce_div = 2'd0; ce_en = 1'b1;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (cpu_ack) acks++;
         if (i == 3) vid_addr = 17'h00300;
         if (i >= 3 && i <= 5) begin
            n_cmp++; if (vid_dout !== 8'h00) begin n_fail++; $display("FAIL rst_first_cap_early: got %h want 00 at i=%0d", vid_dout, i); end
         end
         if (i == 6) begin
            n_cmp++; if (vid_dout !== 8'h77) begin n_fail++; $display("FAIL rst_first_cap: got %h want 77", vid_dout); end
         end
      end
      n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rst_dropped_ack: got %0d acks want 0", acks); end
   endtask

   task automatic test_video_read();
      wait_ph(2'd0);
      vid_addr = 17'h00100;
      tick();
      n_cmp++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL vid_mem_rd: got %b want 1", mem_rd); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL vid_mem_we: got %b want 0", mem_we); end
      n_cmp++; if (mem_addr !== 17'h00100) begin n_fail++; $display("FAIL vid_mem_addr: got %h want 00100", mem_addr); end
      tick(); tick();
      n_cmp++; if (vid_dout !== 8'hA5) begin n_fail++; $display("FAIL vid_dout_ph3: got %h want a5", vid_dout); end
      tick();
      vid_addr = 17'h00200;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (vid_dout !== 8'hA5) begin n_fail++; $display("FAIL vid_dout_hold: got %h want a5 at i=%0d", vid_dout, i); end
         tick();
      end
      n_cmp++; if (vid_dout !== 8'h11) begin n_fail++; $display("FAIL vid_dout_next: got %h want 11", vid_dout); end
   endtask

   task automatic test_cpu_write();
      wait_ph(2'd0);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h1FFFF; cpu_wdata = 8'h3C;
      tick(); tick();
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_early_we: got %b want 0", mem_we); end
      tick();
      n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
      n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL wr_mem_rd: got %b want 0", mem_rd); end
      n_cmp++; if (mem_addr !== 17'h1FFFF) begin n_fail++; $display("FAIL wr_mem_addr: got %h want 1ffff", mem_addr); end
      n_cmp++; if (mem_wdata !== 8'h3C) begin n_fail++; $display("FAIL wr_mem_wdata: got %h want 3c", mem_wdata); end
      tick();
      vid_addr = 17'h1FFFF;
      n_cmp++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_early: got %b want 0", cpu_ack); end
      tick();
      n_cmp++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", cpu_ack); end
      n_cmp++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL wr_rdata_unchanged: got %h want 00", cpu_rdata); end
      cpu_req = 1'b0;
      tick();
      n_cmp++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse: got %b want 0", cpu_ack); end
      tick();
      n_cmp++; if (vid_dout !== 8'h3C) begin n_fail++; $display("FAIL wr_coherent_vid: got %h want 3c", vid_dout); end
   endtask

   task automatic test_back_to_back_read();
      int acks, first, second;
      wait_ph(2'd0);
      vid_addr = 17'h00200;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00010;
      acks = 0; first = -1; second = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         n_cmp++; if (mem_rd && mem_we) begin n_fail++; $display("FAIL b2b_op_excl: got rd=1 we=1 want not both at i=%0d", i); end
         if (cpu_ack) begin
            acks++;
            n_cmp++; if (cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL b2b_rdata: got %h want 5a ack %0d", cpu_rdata, acks); end
            if (acks == 1) first = i;
            else begin second = i; cpu_req = 1'b0; end
         end
         if (i >= 3 && ce_div == 2'd3) begin
            n_cmp++; if (vid_dout !== 8'h11) begin n_fail++; $display("FAIL b2b_vid: got %h want 11 at i=%0d", vid_dout, i); end
         end
      end
      cpu_req = 1'b0;
      n_cmp++; if (acks !== 2) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 2", acks); end
      n_cmp++; if (first !== 5) begin n_fail++; $display("FAIL b2b_first_lat: got %0d want 5", first); end
      n_cmp++; if (second - first !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", second - first); end
      n_cmp++; if (cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL b2b_rdata_hold: got %h want 5a", cpu_rdata); end
   endtask

   task automatic test_early_ce();
      wait_ph(2'd0);
      vid_addr = 17'h00100;
      tick();
      n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 17'h00100) begin n_fail++; $display("FAIL early_rd: got rd=%b addr=%h want rd=1 addr=00100", mem_rd, mem_addr); end
      ce_pix = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00400; cpu_wdata = 8'h99;
      tick();
      vid_addr = 17'h00200;
      n_cmp++; if (vid_dout !== 8'h11 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL early_resync: got dout=%h rd=%b want dout=11 rd=0", vid_dout, mem_rd); end
      tick();
      n_cmp++; if (vid_dout !== 8'hA5) begin n_fail++; $display("FAIL early_cap: got %h want a5", vid_dout); end
      n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 17'h00200) begin n_fail++; $display("FAIL early_next_rd: got rd=%b addr=%h want rd=1 addr=00200", mem_rd, mem_addr); end
      tick();
      n_cmp++; if (vid_dout !== 8'hA5) begin n_fail++; $display("FAIL early_cap_hold: got %h want a5", vid_dout); end
      tick();
      n_cmp++; if (vid_dout !== 8'h11) begin n_fail++; $display("FAIL early_cap_next: got %h want 11", vid_dout); end
      n_cmp++; if (mem_we !== 1'b1 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL early_cpu_op: got we=%b rd=%b want we=1 rd=0", mem_we, mem_rd); end
      tick();
      n_cmp++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL early_ack_early: got %b want 0", cpu_ack); end
      tick();
      n_cmp++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL early_ack: got %b want 1", cpu_ack); end
      cpu_req = 1'b0;
   endtask

   task automatic test_free_run();
      int lat, t0;
      wait_ph(2'd0);
      ce_en = 1'b0;
      vid_addr = 17'h00200;
      lat = -1; t0 = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (ce_div == 2'd1) begin
            n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 17'h00200) begin n_fail++; $display("FAIL free_vid_slot: got rd=%b addr=%h want rd=1 addr=00200 at i=%0d", mem_rd, mem_addr, i); end
         end
         if (ce_div == 2'd3) begin
            n_cmp++; if (vid_dout !== 8'h11) begin n_fail++; $display("FAIL free_vid_dout: got %h want 11 at i=%0d", vid_dout, i); end
         end
         if (cpu_ack) begin
            lat = i - t0;
            cpu_req = 1'b0;
            n_cmp++; if (cpu_rdata !== 8'h77) begin n_fail++; $display("FAIL free_rdata: got %h want 77", cpu_rdata); end
         end
         if (i == 3) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00300; t0 = i;
         end
      end
      n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL free_ack_latency: got %0d want 6", lat); end
      cpu_req = 1'b0;
      ce_en = 1'b1;
   endtask

   initial begin
      reset = 1'b1; ce_pix = 1'b0; ce_en = 1'b0; ce_div = 2'd0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; vid_addr = '0;
      test_reset();
      test_video_read();
      test_cpu_write();
      test_back_to_back_read();
      test_early_ce();
      test_free_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
